// File: rtl/spi_slave_mode0.sv
// spi_slave_mode0 -- SPI mode-0 (CPOL=0, CPHA=0) slave endpoint.
//
// Receives MSB-first bytes on mosi (sampled on rising sclk) into rx_data and
// transmits bytes from a small TX FIFO on miso (launched on falling sclk).
// All logic runs on sclk. The rising-edge and falling-edge halves exchange
// state only over half-cycle paths.
//
// Build option: define SPI_SLAVE_ECHO_EN to send the last received byte
// (rx_data) as the fill byte on TX underrun. Otherwise the fill byte is 8'h00.
//
// Ports:
//   sclk        in   SPI clock, local clock for all logic
//   rst         in   asynchronous reset, active-low
//   cs          in   chip select, active-low (high = idle / abort)
//   mosi        in   serial data from master
//   miso        out  serial data to master (changes on falling sclk only)
//   tx_data     in   byte to enqueue for transmission
//   tx_valid    in   enqueue request, sampled on rising sclk
//   tx_ready    out  TX FIFO not full
//   rx_data     out  last complete received byte
//   rx_valid    out  one-cycle pulse when rx_data updates
//   tx_underrun out  sticky: a byte was launched with the FIFO empty
module spi_slave_mode0 #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr;     // rising-edge domain
  logic [AW:0] rd_ptr;     // falling-edge domain
  logic        full;
  logic        empty;
  logic        wr_en;
  logic [7:0]  head;
  logic [7:0]  fill;

  logic [2:0]  rx_bit;
  logic [6:0]  rx_shift;
  logic [2:0]  tx_bit;
  logic [6:0]  tx_shift;

  // The underrun flag is set on falling edges and cleared on rising edges.
  // Each edge owns one bit, and the flag is their XOR. A set makes the bits
  // differ, and a clear copies the set bit so they match again.
  logic        und_set;  // falling-edge domain
  logic        und_clr;  // rising-edge domain

  assign full        = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign tx_ready    = ~full;
  assign wr_en       = tx_valid & ~full;
  assign head        = mem[rd_ptr[AW-1:0]];
  assign tx_underrun = und_set ^ und_clr;

`ifdef SPI_SLAVE_ECHO_EN
  assign fill = rx_data;
`else
  assign fill = '0;
`endif

  // FIFO storage: contents are meaningful only between the pointers, so the
  // array itself needs no reset.
  always_ff @(posedge sclk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= tx_data;
    end
  end

  // Rising edge: receive path, FIFO write side, underrun clear.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      und_clr  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (cs) begin
        rx_bit   <= '0;
        rx_shift <= '0;
        rx_valid <= 1'b0;
        und_clr  <= und_set;
      end else begin
        rx_shift <= {rx_shift[5:0], mosi};
        rx_bit   <= rx_bit + 3'd1;
        rx_valid <= (rx_bit == 3'd7);
        if (rx_bit == 3'd7) begin
          rx_data <= {rx_shift, mosi};
        end
      end
    end
  end

  // Falling edge: transmit path, FIFO read side, underrun set.
  always_ff @(negedge sclk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      miso     <= 1'b0;
      und_set  <= 1'b0;
    end else if (cs) begin
      tx_bit <= '0;
      miso   <= 1'b0;
    end else begin
      tx_bit <= tx_bit + 3'd1;
      if (tx_bit == 3'd0) begin
        if (!empty) begin
          miso     <= head[7];
          tx_shift <= head[6:0];
          rd_ptr   <= rd_ptr + PTR_ONE;
        end else begin
          miso     <= fill[7];
          tx_shift <= fill[6:0];
          und_set  <= ~und_clr;
        end
      end else begin
        miso     <= tx_shift[6];
        tx_shift <= {tx_shift[5:0], 1'b0};
      end
    end
  end

endmodule
